// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard controller producing per-stage stall, bubble and flush controls
// plus a memory-wait watchdog. Define HAZARD_PERF_CNT_EN to build the stall_cycle_cnt counter.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs_addr,
    input  logic        id_rs_used,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_rt_used,
    input  logic        id_uses_hilo,
    input  logic [4:0]  ex_dest_addr,
    input  logic [1:0]  ex_access_type,
    input  logic [1:0]  mm_access_type,
    input  logic        mm_data_ready,
    input  logic        mdu_busy,
    input  logic        exc_flush,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mm,
    output logic        bubble_ex,
    output logic        bubble_wb,
    output logic        flush_all,
    output logic        bus_timeout,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycle_cnt
);
    localparam logic [1:0] MEM_ACCESS_TYPE_M2R = 2'd1;
    localparam logic [1:0] MEM_ACCESS_TYPE_R2M = 2'd2;

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_LOAD_BUBBLE = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT    = 2'd2;
    localparam logic [1:0] ST_MDU_WAIT    = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic       load_use;
    logic       mem_wait;
    logic       mdu_wait;
    logic       flush;
    logic [1:0] ctrl_state_q, ctrl_state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_timeout_q, bus_timeout_d;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = (ex_access_type == MEM_ACCESS_TYPE_M2R) && (ex_dest_addr != 5'd0) &&
                      ((id_rs_used && (id_rs_addr == ex_dest_addr)) ||
                       (id_rt_used && (id_rt_addr == ex_dest_addr)));
    assign mem_wait = ((mm_access_type == MEM_ACCESS_TYPE_M2R) ||
                       (mm_access_type == MEM_ACCESS_TYPE_R2M)) && !mm_data_ready;
    assign mdu_wait = id_uses_hilo && mdu_busy;
    assign flush    = rst_n || exc_flush || bus_timeout_q;

    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mm     = 1'b0;
        bubble_ex    = 1'b0;
        bubble_wb    = 1'b0;
        flush_all    = 1'b0;
        ctrl_state_d = ST_RUN;
        if (flush) begin
            flush_all = 1'b1;
        end else if (mem_wait) begin
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            stall_ex     = 1'b1;
            stall_mm     = 1'b1;
            bubble_wb    = 1'b1;
            ctrl_state_d = ST_MEM_WAIT;
        end else if (mdu_wait) begin
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            bubble_ex    = 1'b1;
            ctrl_state_d = ST_MDU_WAIT;
        end else if (load_use) begin
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            bubble_ex    = 1'b1;
            ctrl_state_d = ST_LOAD_BUBBLE;
        end
    end

    // Watchdog counts consecutive unflushed wait cycles; expiry raises a one-cycle timeout that flushes.
    always_comb begin
        wait_cnt_d    = 8'd0;
        bus_timeout_d = 1'b0;
        if (!flush && mem_wait) begin
            if (wait_cnt_q == WAIT_LAST) begin
                bus_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ctrl_state_q  <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            bus_timeout_q <= 1'b0;
        end else begin
            ctrl_state_q  <= ctrl_state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign ctrl_state  = ctrl_state_q;
    assign bus_timeout = bus_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    // Survives flushes on purpose; only a reset clears it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            perf_cnt_q <= 32'd0;
        end else if (stall_if) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign stall_cycle_cnt = perf_cnt_q;
`else
    assign stall_cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: randomized plus directed stimulus for hazard_stall_ctrl, checked by a
// scoreboard fed from a behavioural model of the hazard priority rules and the watchdog.
module tb_hazard_stall_ctrl;
    localparam int unsigned MEM_TO = 8;
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_M2R  = 2'd1;
    localparam logic [1:0] ACC_R2M  = 2'd2;

    typedef struct packed {
        logic [4:0] rsA;
        logic       rsU;
        logic [4:0] rtA;
        logic       rtU;
        logic       hilo;
        logic [4:0] exD;
        logic [1:0] exT;
        logic [1:0] mmT;
        logic       rdy;
        logic       busy;
        logic       exc;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic        sIf;
        logic        sId;
        logic        sEx;
        logic        sMm;
        logic        bEx;
        logic        bWb;
        logic        fl;
        logic        to;
        logic [1:0]  st;
        logic [31:0] perf;
    } resp_t;

    logic  clk = 1'b0;
    stim_t curStim;
    resp_t got;
    resp_t expQ[$];
    int    total = 0;
    int    bad = 0;
    int    cycle = 0;

    // Behavioural model state
    int          mState = 0;
    int          mRunLen = 0;
    bit          mTimeout = 1'b0;
    bit [31:0]   mPerf = 32'd0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TO)) dut (
        .clk            (clk),
        .rst_n          (curStim.rst),
        .id_rs_addr     (curStim.rsA),
        .id_rs_used     (curStim.rsU),
        .id_rt_addr     (curStim.rtA),
        .id_rt_used     (curStim.rtU),
        .id_uses_hilo   (curStim.hilo),
        .ex_dest_addr   (curStim.exD),
        .ex_access_type (curStim.exT),
        .mm_access_type (curStim.mmT),
        .mm_data_ready  (curStim.rdy),
        .mdu_busy       (curStim.busy),
        .exc_flush      (curStim.exc),
        .stall_if       (got.sIf),
        .stall_id       (got.sId),
        .stall_ex       (got.sEx),
        .stall_mm       (got.sMm),
        .bubble_ex      (got.bEx),
        .bubble_wb      (got.bWb),
        .flush_all      (got.fl),
        .bus_timeout    (got.to),
        .ctrl_state     (got.st),
        .stall_cycle_cnt(got.perf)
    );

    // Winner of the hazard priority: 4 flush, 2 mem wait, 3 mdu wait, 1 load-use, 0 none.
    function automatic int winner(input stim_t s);
        bit memBusy = (s.mmT == ACC_M2R || s.mmT == ACC_R2M) && !s.rdy;
        bit ldHit = (s.exT == ACC_M2R) && (s.exD != 0) &&
                    ((s.rsU && s.rsA == s.exD) || (s.rtU && s.rtA == s.exD));
        if (s.rst || s.exc || mTimeout) return 4;
        if (memBusy) return 2;
        if (s.hilo && s.busy) return 3;
        if (ldHit) return 1;
        return 0;
    endfunction

    function automatic resp_t predict(input stim_t s);
        resp_t r = '0;
        int w = winner(s);
        r.fl  = (w == 4);
        r.sIf = (w == 1 || w == 2 || w == 3);
        r.sId = r.sIf;
        r.sEx = (w == 2);
        r.sMm = (w == 2);
        r.bWb = (w == 2);
        r.bEx = (w == 1 || w == 3);
        r.to  = mTimeout;
        r.st  = 2'(mState);
`ifdef HAZARD_PERF_CNT_EN
        r.perf = mPerf;
`else
        r.perf = 32'd0;
`endif
        return r;
    endfunction

    // Clock edge in the model: state follows the winner, watchdog counts the unbroken wait run.
    task automatic modelAdvance(input stim_t s);
        int w = winner(s);
        if (s.rst) begin
            mState = 0;
            mRunLen = 0;
            mTimeout = 1'b0;
            mPerf = 32'd0;
        end else begin
            if (w == 1 || w == 2 || w == 3) mPerf = mPerf + 32'd1;
            mState = (w == 4) ? 0 : w;
            mTimeout = 1'b0;
            if (w == 2) begin
                mRunLen = mRunLen + 1;
                if (mRunLen == MEM_TO) begin
                    mTimeout = 1'b1;
                    mRunLen = 0;
                end
            end else begin
                mRunLen = 0;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        modelAdvance(curStim);
        #1;
        curStim = s;
        expQ.push_back(predict(s));
    endtask

    task automatic checkOutput(input resp_t g, input resp_t w);
        total++;
        if (g !== w) begin
            bad++;
            $display("[TB] FAIL outputs cycle=%0d got=%h want=%h (sIf sId sEx sMm bEx bWb fl to st perf)",
                     cycle, g, w);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rsA  = 5'($urandom_range(0, 3));
        s.rsU  = 1'($urandom);
        s.rtA  = 5'($urandom_range(0, 3));
        s.rtU  = 1'($urandom);
        s.hilo = 1'($urandom);
        s.exD  = 5'($urandom_range(0, 3));
        s.exT  = 2'($urandom);
        s.mmT  = 2'($urandom);
        s.rdy  = 1'($urandom);
        s.busy = 1'($urandom);
        s.exc  = ($urandom_range(0, 19) == 0);
        s.rst  = ($urandom_range(0, 99) == 0);
        return s;
    endfunction

    // Monitor: the DUT presents a response every cycle; sample mid-cycle and score it.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (expQ.size() > 0) checkOutput(got, expQ.pop_front());
        end
    end

    initial begin
        stim_t s;
        curStim = idle();
        curStim.rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = idle();
            s.rst = 1'b1;
            applyStimulus(s);
        end
        applyStimulus(idle());

        // Load r3 in EX used by ID rs, then the load moves on
        s = idle(); s.exT = ACC_M2R; s.exD = 5'd3; s.rsA = 5'd3; s.rsU = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        // Load to r0 never stalls
        s = idle(); s.exT = ACC_M2R; s.exD = 5'd0; s.rsA = 5'd0; s.rsU = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        // Four-cycle memory wait, then acknowledge
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.mmT = ACC_M2R; s.rdy = (i == 4);
            applyStimulus(s);
        end
        applyStimulus(idle());

        // Memory never acknowledges: watchdog expiry and the wait resuming afterwards
        for (int i = 0; i < 2 * MEM_TO + 4; i++) begin
            s = idle(); s.mmT = ACC_R2M; s.rdy = 1'b0;
            applyStimulus(s);
        end
        applyStimulus(idle());

        // MDU busy with a pending load-use for ten cycles, then the lone load bubble
        for (int i = 0; i < 11; i++) begin
            s = idle(); s.exT = ACC_M2R; s.exD = 5'd5; s.rtA = 5'd5; s.rtU = 1'b1;
            s.hilo = 1'b1; s.busy = (i < 10);
            applyStimulus(s);
        end
        applyStimulus(idle());

        // Exception flush mid-wait, then a reset pulse mid-wait
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.mmT = ACC_M2R; s.rdy = 1'b0;
            s.exc = (i == 3);
            s.rst = (i == 6);
            applyStimulus(s);
        end
        applyStimulus(idle());

        // Random traffic with occasional long memory waits
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                int n = $urandom_range(1, 2 * MEM_TO);
                for (int k = 0; k < n; k++) begin
                    s = randStim();
                    s.mmT = ($urandom_range(0, 1) != 0) ? ACC_M2R : ACC_R2M;
                    s.rdy = 1'b0;
                    s.exc = 1'b0;
                    s.rst = 1'b0;
                    applyStimulus(s);
                end
            end else begin
                applyStimulus(randStim());
            end
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain leftover=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core, placed in the ID stage next to the register bypass muxes. It handles the hazards forwarding cannot resolve: load-use, memory wait, HI/LO busy, and flush. For each one it produces per-stage stall, bubble and flush controls. It also runs a memory-wait watchdog and records its state for debug.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: memory-wait cycles before a bus timeout is declared; 8-bit counter, legal range 1..255.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-high (1 = reset); codebase port name kept
- id_rs_addr  input  5  rs source register of the instruction in ID
- id_rs_used  input  1  ID instruction reads rs
- id_rt_addr  input  5  rt source register of the instruction in ID
- id_rt_used  input  1  ID instruction reads rt
- id_uses_hilo  input  1  ID instruction reads or writes HI/LO
- ex_dest_addr  input  5  destination register in EX
- ex_access_type  input  2  EX access type (`MEM_ACCESS_TYPE_*` from defs.v)
- mm_access_type  input  2  MM access type
- mm_data_ready  input  1  memory acknowledge for the MM access
- mdu_busy  input  1  mult/div unit still computing
- exc_flush  input  1  exception or eret flush request
- stall_if, stall_id, stall_ex, stall_mm  output  1 each  hold the stage's pipeline register
- bubble_ex  output  1  load a NOP into ID/EX
- bubble_wb  output  1  load a NOP into MM/WB
- flush_all  output  1  clear IF/ID, ID/EX, EX/MM and MM/WB
- bus_timeout  output  1  one-cycle pulse when the watchdog expires
- ctrl_state  output  2  registered state: 0 RUN, 1 LOAD_BUBBLE, 2 MEM_WAIT, 3 MDU_WAIT
- stall_cycle_cnt  output  32  performance counter (see Configuration)

## Operation
Hazard conditions, all combinational:
- load_use = ex_access_type==M2R && ex_dest_addr!=0 && ((id_rs_used && id_rs_addr==ex_dest_addr) || (id_rt_used && id_rt_addr==ex_dest_addr)).
- mem_wait = (mm_access_type==M2R || mm_access_type==R2M) && !mm_data_ready.
- mdu_wait = id_uses_hilo && mdu_busy.

Output priority, highest first; outputs not listed are 0:
- rst_n, exc_flush or bus_timeout → flush_all=1 only.
- mem_wait → stall_if, stall_id, stall_ex and stall_mm = 1; bubble_wb=1.
- mdu_wait → stall_if=1, stall_id=1, bubble_ex=1.
- load_use → stall_if=1, stall_id=1, bubble_ex=1.
- None → all 0 (RUN).

State register:
- Next state is the winning condition: LOAD_BUBBLE, MEM_WAIT or MDU_WAIT, otherwise RUN.
- A flush forces RUN.

Watchdog (8-bit wait_cnt):
- Increments every cycle that mem_wait is set and no flush is active.
- Clears when mem_wait is clear.
- When wait_cnt==MEM_TIMEOUT-1 with mem_wait still set, the next edge sets bus_timeout=1 and clears wait_cnt.
- bus_timeout self-clears after one cycle.
- MM is responsible for aborting the access on flush_all.

Load-use behaviour:
- Costs exactly one bubble.
- After the bubble the load sits in MM as M2R and is forwarded by the bypass mux.
- No stall is produced for ex_dest_addr==0.

## Timing
- All stall, bubble and flush outputs are combinational from current inputs plus the registered bus_timeout; zero-cycle latency.
- ctrl_state, wait_cnt and bus_timeout update on the rising edge.
- Reset values: ctrl_state=0, wait_cnt=0, bus_timeout=0, stall_cycle_cnt=0. During reset flush_all=1 and all stalls and bubbles are 0.
- Simultaneous events: mem_wait with load_use gives the mem_wait response only. load_use is re-evaluated after MM completes, because EX is held.
- mm_data_ready in the first cycle of an access means no stall and no count.
- exc_flush during MEM_WAIT: flush wins, wait_cnt clears, state becomes RUN next cycle.
- Reset mid-wait clears everything on the next edge.
- A mem stall of N cycles with MEM_TIMEOUT>N produces N cycles of stall_mm and no timeout.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycle_cnt increments each cycle stall_if=1 and rst_n=0.
  - Wraps at 2^32; not cleared by flush.
- Undefined: stall_cycle_cnt is tied to 0 and no counter register is synthesized.

## Test plan
- Load r3 in EX (M2R, dest 3), ID reads rs=3 → one cycle of stall_if/stall_id/bubble_ex, ctrl_state=1, then RUN.
- Load dest 0 in EX, ID reads rs=0 → no stall.
- MM M2R with mm_data_ready low 4 cycles, MEM_TIMEOUT=255 → stall_mm and bubble_wb high exactly 4 cycles, no bus_timeout.
- MEM_TIMEOUT=8, mm_data_ready held low → bus_timeout pulses after 8 wait cycles, flush_all high that cycle, state RUN.
- mdu_busy=1 with id_uses_hilo=1 for 10 cycles while load_use is also true → MDU response (ctrl_state=3) for 10 cycles, then one LOAD_BUBBLE; with HAZARD_PERF_CNT_EN, stall_cycle_cnt advances by 11.
- exc_flush asserted during MEM_WAIT, then rst_n pulse → flush_all=1, all stalls 0, wait_cnt and ctrl_state at 0.
